// File: rtl/gcd_lcm_master.sv
// Request sequencer for an external GCD/LCM engine: captures operands, issues one start pulse,
// waits with a timeout, cross-checks mcd*lcm against a*b and holds the result for handshake.
module gcd_lcm_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic [DATA_W-1:0]   eng_a,
  output logic [DATA_W-1:0]   eng_b,
  output logic                eng_vld,
  input  logic [DATA_W-1:0]   eng_mcd,
  input  logic [2*DATA_W-1:0] eng_lcm,
  input  logic                eng_vld_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_a,
  output logic [DATA_W-1:0]   res_b,
  output logic [DATA_W-1:0]   res_mcd,
  output logic [2*DATA_W-1:0] res_lcm,
  output logic                res_err,
  output logic                res_zero,
  output logic                res_timeout,
  output logic [7:0]          spurious_cnt
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;

  // Counter value during the last permitted WAIT cycle.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [2:0]          state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, mcd_q, mcd_d;
  logic [2*DATA_W-1:0] lcm_q, lcm_d;
  logic                err_q, err_d, zero_q, zero_d, timeout_q, timeout_d;
  logic [7:0]          cnt_q, cnt_d, spur_q, spur_d;

  logic [2*DATA_W-1:0] ops_mul;
  logic [3*DATA_W-1:0] prod_ops, prod_res;

  always_comb begin
    ops_mul  = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    prod_ops = {{DATA_W{1'b0}}, ops_mul};
    prod_res = {{(2*DATA_W){1'b0}}, mcd_q} * {{DATA_W{1'b0}}, lcm_q};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mcd_d     = mcd_q;
    lcm_d     = lcm_q;
    err_d     = err_q;
    zero_d    = zero_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    spur_d    = spur_q;

    // Strobes outside WAIT are only counted; they never disturb the request in flight.
    if (eng_vld_out && (state_q != StWait) && (spur_q != 8'hFF)) begin
      spur_d = spur_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            zero_d  = 1'b1;
            mcd_d   = '0;
            lcm_d   = '0;
            state_d = StHold;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (eng_vld_out) begin
          mcd_d   = eng_mcd;
          lcm_d   = eng_lcm;
          state_d = StCheck;
        end else if (cnt_q == TimeoutLast) begin
          timeout_d = 1'b1;
          mcd_d     = '0;
          lcm_d     = '0;
          state_d   = StHold;
        end
      end
      StCheck: begin
        err_d   = (prod_res != prod_ops);
        state_d = StHold;
      end
      StHold: begin
        if (res_ready) begin
          err_d     = 1'b0;
          zero_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      mcd_q     <= '0;
      lcm_q     <= '0;
      err_q     <= 1'b0;
      zero_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= 8'd0;
      spur_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mcd_q     <= mcd_d;
      lcm_q     <= lcm_d;
      err_q     <= err_d;
      zero_q    <= zero_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      spur_q    <= spur_d;
    end
  end

  logic eng_active;

  always_comb begin
    eng_active   = (state_q == StIssue) || (state_q == StWait);
    in_ready     = (state_q == StIdle);
    eng_vld      = (state_q == StIssue);
    eng_a        = eng_active ? a_q : '0;
    eng_b        = eng_active ? b_q : '0;
    res_valid    = (state_q == StHold);
    res_a        = a_q;
    res_b        = b_q;
    res_mcd      = mcd_q;
    res_lcm      = lcm_q;
    res_err      = err_q;
    res_zero     = zero_q;
    res_timeout  = timeout_q;
    spurious_cnt = spur_q;
  end

endmodule

// File: tb/tb_gcd_lcm_master.sv
// Self-checking bench for gcd_lcm_master: directed vector table, randomized requests against an
// arithmetic reference model, plus reset-mid-request and spurious-counter saturation sequences.
module tb_gcd_lcm_master;

  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          clk, rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_a, in_b;
  logic [DW-1:0] eng_a, eng_b;
  logic          eng_vld;
  logic [DW-1:0] eng_mcd;
  logic [2*DW-1:0] eng_lcm;
  logic          eng_vld_out;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_a, res_b, res_mcd;
  logic [2*DW-1:0] res_lcm;
  logic          res_err, res_zero, res_timeout;
  logic [7:0]    spurious_cnt;

  gcd_lcm_master #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .eng_a(eng_a), .eng_b(eng_b), .eng_vld(eng_vld),
    .eng_mcd(eng_mcd), .eng_lcm(eng_lcm), .eng_vld_out(eng_vld_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_a(res_a), .res_b(res_b), .res_mcd(res_mcd), .res_lcm(res_lcm),
    .res_err(res_err), .res_zero(res_zero), .res_timeout(res_timeout),
    .spurious_cnt(spurious_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_id  = 0;
  int spur_exp = 0;

  typedef struct {
    logic [7:0]  a, b;
    int          d;
    bit          silent;
    logic [7:0]  m;
    logic [15:0] l;
    logic [7:0]  emcd;
    logic [15:0] elcm;
    bit          eerr, ezero, eto;
    int          hold;
    bit          spur;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (case %0d): got %0h, expected %0h", name, cur_id, got, exp);
    end
  endtask

  function automatic int gcd_f(input int x, input int y);
    int t;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  // One full request: accept, act as engine, check result, hold, handshake.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int d, input bit silent,
                         input logic [7:0] m, input logic [15:0] l,
                         input logic [7:0] emcd, input logic [15:0] elcm,
                         input bit eerr, input bit ezero, input bit eto,
                         input int hold, input bit spur);
    int n, lat, exp_lat, pulses;
    bit bad_ready, stable, is_zero;
    logic [7:0] sa, sb, smcd;
    logic [15:0] slcm;
    logic se, sz, st;
    is_zero = (a == 0) || (b == 0);
    exp_lat = is_zero ? 1 : (silent ? 2 + int'(TO) : 3 + d);
    check("in_ready_before_req", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    eng_mcd = m;
    eng_lcm = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
    n = 1;
    pulses = 0;
    lat = -1;
    bad_ready = 1'b0;
    while (lat < 0 && n <= 60) begin
      if (eng_vld) begin
        pulses++;
        check("eng_a_at_issue", eng_a, a);
        check("eng_b_at_issue", eng_b, b);
      end
      if (in_ready) bad_ready = 1'b1;
      if (res_valid) begin
        lat = n;
      end else begin
        eng_vld_out = !silent && !is_zero && (n == 1 + d);
        if (eng_vld_out) begin
          check("eng_a_in_wait", eng_a, a);
          check("eng_b_in_wait", eng_b, b);
        end
        @(negedge clk);
        eng_vld_out = 1'b0;
        n++;
      end
    end
    check("res_valid_within_budget", lat >= 0, 1);
    check("latency", lat, exp_lat);
    check("in_ready_busy", bad_ready, 0);
    check("eng_vld_pulses", pulses, is_zero ? 0 : 1);
    check("res_a", res_a, a);
    check("res_b", res_b, b);
    check("res_mcd", res_mcd, emcd);
    check("res_lcm", res_lcm, elcm);
    check("res_err", res_err, eerr);
    check("res_zero", res_zero, ezero);
    check("res_timeout", res_timeout, eto);
    sa = res_a; sb = res_b; smcd = res_mcd; slcm = res_lcm;
    se = res_err; sz = res_zero; st = res_timeout;
    res_ready = 1'b0;
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      if (spur && k == hold / 2) begin
        eng_vld_out = 1'b1;
        spur_exp = (spur_exp < 255) ? spur_exp + 1 : 255;
      end
      @(negedge clk);
      eng_vld_out = 1'b0;
      if (!res_valid || in_ready || res_a !== sa || res_b !== sb || res_mcd !== smcd ||
          res_lcm !== slcm || res_err !== se || res_zero !== sz || res_timeout !== st)
        stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("spurious_cnt", spurious_cnt, spur_exp);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_after_hs", res_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
    check("flags_clear", {res_err, res_zero, res_timeout}, 0);
  endtask

  initial begin
    logic [7:0] ra, rb, rm;
    logic [15:0] rl;
    int rd, g;
    bit rsil, rz, rerr;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    eng_mcd = '0; eng_lcm = '0; eng_vld_out = 1'b0;
    res_ready = 1'b0;

    //               a    b    d  sil m    l      emcd elcm  err z  to hold spur
    vecs[0]  = '{8'd12,  8'd18,  5, 0, 8'd6,   16'd36,  8'd6,   16'd36,  0, 0, 0, 0,  0};
    vecs[1]  = '{8'd12,  8'd18,  5, 0, 8'd6,   16'd30,  8'd6,   16'd30,  1, 0, 0, 2,  0};
    vecs[2]  = '{8'd0,   8'd7,   3, 0, 8'd1,   16'd1,   8'd0,   16'd0,   0, 1, 0, 0,  0};
    vecs[3]  = '{8'd9,   8'd0,   3, 0, 8'd1,   16'd1,   8'd0,   16'd0,   0, 1, 0, 1,  0};
    vecs[4]  = '{8'd12,  8'd18,  0, 1, 8'd6,   16'd36,  8'd0,   16'd0,   0, 0, 1, 0,  0};
    vecs[5]  = '{8'd12,  8'd18, 16, 0, 8'd6,   16'd36,  8'd6,   16'd36,  0, 0, 0, 0,  0};
    vecs[6]  = '{8'd12,  8'd18,  5, 0, 8'd6,   16'd36,  8'd6,   16'd36,  0, 0, 0, 10, 1};
    vecs[7]  = '{8'd255, 8'd255, 3, 0, 8'd255, 16'd255, 8'd255, 16'd255, 0, 0, 0, 0,  0};
    vecs[8]  = '{8'd1,   8'd1,   1, 0, 8'd1,   16'd1,   8'd1,   16'd1,   0, 0, 0, 0,  0};
    vecs[9]  = '{8'd200, 8'd150, 2, 0, 8'd50,  16'd600, 8'd50,  16'd600, 0, 0, 0, 3,  1};
    vecs[10] = '{8'd13,  8'd17,  4, 0, 8'd1,   16'd220, 8'd1,   16'd220, 1, 0, 0, 0,  0};
    vecs[11] = '{8'd0,   8'd0,   2, 0, 8'd5,   16'd5,   8'd0,   16'd0,   0, 1, 0, 4,  1};

    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_eng_vld", eng_vld, 0);
    check("rst_eng_ab", {eng_a, eng_b}, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", {res_a, res_b, res_mcd, res_lcm}, 0);
    check("rst_flags", {res_err, res_zero, res_timeout}, 0);
    check("rst_spurious", spurious_cnt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      cur_id = i;
      run_txn(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].silent, vecs[i].m, vecs[i].l,
              vecs[i].emcd, vecs[i].elcm, vecs[i].eerr, vecs[i].ezero, vecs[i].eto,
              vecs[i].hold, vecs[i].spur);
    end

    // Randomized requests; expectations from plain arithmetic on the operands.
    for (int i = 0; i < 40; i++) begin
      cur_id = 100 + i;
      ra = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      rsil = ($urandom_range(0, 7) == 0);
      rd = $urandom_range(1, TO);
      rz = (ra == 0) || (rb == 0);
      if (rz) begin
        rm = 8'd1; rl = 16'd1;
      end else begin
        g = gcd_f(int'(ra), int'(rb));
        rm = 8'(g);
        rl = 16'((int'(ra) * int'(rb)) / g);
        if ($urandom_range(0, 3) == 0) rl = rl ^ (16'd1 << $urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) rm = 8'($urandom);
      end
      rerr = !rz && !rsil && (longint'(rm) * longint'(rl) != longint'(ra) * longint'(rb));
      run_txn(ra, rb, rd, rsil, rm, rl,
              (rz || rsil) ? 8'd0 : rm, (rz || rsil) ? 16'd0 : rl,
              rerr, rz, !rz && rsil, $urandom_range(0, 3), ($urandom_range(0, 2) == 0));
    end

    // Reset in the middle of WAIT abandons the request.
    cur_id = 200;
    in_valid = 1'b1; in_a = 8'd12; in_b = 8'd18;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    spur_exp = 0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_eng", {eng_vld, eng_a, eng_b}, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_data", {res_a, res_b, res_mcd, res_lcm}, 0);
    check("midrst_flags", {res_err, res_zero, res_timeout}, 0);
    check("midrst_spurious", spurious_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    eng_mcd = 8'd6; eng_lcm = 16'd36;
    eng_vld_out = 1'b1;
    @(negedge clk);
    eng_vld_out = 1'b0;
    spur_exp = 1;
    begin
      bit quiet;
      quiet = 1'b1;
      for (int k = 0; k < 20; k++) begin
        if (res_valid || !in_ready || eng_vld) quiet = 1'b0;
        @(negedge clk);
      end
      check("midrst_no_result", quiet, 1);
    end
    check("midrst_spurious_after", spurious_cnt, spur_exp);

    // Spurious counter saturates.
    cur_id = 300;
    for (int k = 0; k < 260; k++) begin
      eng_vld_out = 1'b1;
      spur_exp = (spur_exp < 255) ? spur_exp + 1 : 255;
      @(negedge clk);
    end
    eng_vld_out = 1'b0;
    @(negedge clk);
    check("spurious_saturate", spurious_cnt, spur_exp);
    check("sat_fsm_idle", {in_ready, res_valid}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule

// File: doc/gcd_lcm_master.md
GCD_LCM_MASTER -- requirements
Module: gcd_lcm_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before the request is abandoned; legal range 1..255.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_a input DATA_W, in_b input DATA_W: operand request, valid/ready handshake.
REQ-006 SHALL have ports eng_a output DATA_W, eng_b output DATA_W, eng_vld output 1: operands and start pulse to the GCD/LCM engine.
REQ-007 SHALL have ports eng_mcd input DATA_W, eng_lcm input 2*DATA_W, eng_vld_out input 1: engine result and result strobe.
REQ-008 SHALL have ports res_valid output 1, res_ready input 1, res_a/res_b output DATA_W, res_mcd output DATA_W, res_lcm output 2*DATA_W: result, valid/ready handshake.
REQ-009 SHALL have ports res_err, res_zero, res_timeout output 1 each: status flags qualified by res_valid.
REQ-010 SHALL have port spurious_cnt output 8: saturating count of unexpected eng_vld_out strobes.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, CHECK, HOLD, all registered.
REQ-012 in_ready SHALL equal (state==IDLE), decoded from the state register only.
REQ-013 IDLE: on in_valid&&in_ready, SHALL capture in_a/in_b into res_a/res_b; if either is 0 -> HOLD, else -> ISSUE.
REQ-014 Zero operand: SHALL NOT pulse eng_vld; HOLD with res_zero=1, res_mcd=0, res_lcm=0; res_valid rises 1 cycle after acceptance.
REQ-015 ISSUE: eng_vld SHALL be 1 for exactly this one cycle; eng_a/eng_b SHALL present captured operands from ISSUE through end of WAIT.
REQ-016 eng_vld SHALL be 0 in every state other than ISSUE.
REQ-017 WAIT: SHALL clear the 8-bit wait counter on entry and increment it each WAIT cycle.
REQ-018 WAIT, eng_vld_out=1: SHALL capture eng_mcd/eng_lcm -> CHECK.
REQ-019 WAIT, counter reaches TIMEOUT without eng_vld_out: SHALL -> HOLD with res_timeout=1, res_mcd=0, res_lcm=0.
REQ-020 eng_vld_out and timeout in the same cycle: SHALL treat as result (REQ-018); no timeout.
REQ-021 CHECK: SHALL compute res_mcd*res_lcm (3*DATA_W) against zero-extended res_a*res_b; mismatch sets res_err=1; -> HOLD after exactly one cycle.
REQ-022 res_valid SHALL rise 2 cycles after the edge sampling eng_vld_out.
REQ-023 HOLD: res_valid=1; all res_* outputs and flags SHALL be stable until res_valid&&res_ready; then -> IDLE and res_valid=0 next cycle.
REQ-024 At most one of res_err, res_zero, res_timeout SHALL be 1 per result; all SHALL clear on leaving HOLD.
REQ-025 eng_vld_out seen in any state except WAIT SHALL increment spurious_cnt, saturating at 255, and SHALL NOT change the FSM or res_* values.
REQ-026 Back-to-back: a new request SHALL be accepted no earlier than the cycle after HOLD handshake completes.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, in_ready=1, eng_vld=0, eng_a/eng_b=0, res_valid=0, all res_* and flags 0, wait counter 0, spurious_cnt 0.
REQ-028 Reset mid-request (any state) SHALL abandon the request; no res_valid SHALL be produced for it after release.

Verification
REQ-029 A=12,B=18, engine returns mcd=6,lcm=36 after 5 cycles -> one eng_vld pulse; res_valid with res_mcd=6, res_lcm=36, res_err=0.
REQ-030 A=12,B=18, engine returns mcd=6,lcm=30 -> res_err=1, res_mcd=6, res_lcm=30.
REQ-031 A=0,B=7 -> no eng_vld; res_valid next cycle, res_zero=1, res_mcd=0, res_lcm=0.
REQ-032 TIMEOUT=16, engine silent -> res_timeout=1 after 16 WAIT cycles; strobe in cycle 16 -> normal result instead.
REQ-033 res_ready low 10 cycles in HOLD plus one eng_vld_out pulse -> outputs stable, in_ready=0, spurious_cnt=1.
REQ-034 rst_n pulsed low during WAIT -> all outputs 0, in_ready=1 after release, later eng_vld_out increments spurious_cnt only.
